seq_shifter: RTL

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: sequential shift/rotate register, one bit per SHIFT cycle.
// Ports:
//   clk, rst (sync, active-high)
//   start, op[2:0], amount[AMT_W-1:0], din[WIDTH-1:0], serial_in
//   out[WIDTH-1:0], busy, done, serial_out
module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             serial_out
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_val;
    logic             shift_bit;
    logic             is_shift;

    assign is_shift = (op >= OP_SLL) && (op <= OP_ROR);
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // LOAD, NOP and zero-distance requests finish at once
                    if (is_shift && (amount != '0)) state_d = SHIFT;
                    else                            state_d = DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == AMT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One-bit step for the latched op; only consumed while in SHIFT
    always_comb begin
        shift_val = out;
        shift_bit = serial_out;
        case (op_q)
            OP_SLL: begin
                shift_val = {out[WIDTH-2:0], serial_in};
                shift_bit = out[WIDTH-1];
            end
            OP_SRL: begin
                shift_val = {serial_in, out[WIDTH-1:1]};
                shift_bit = out[0];
            end
            OP_SRA: begin
                shift_val = {out[WIDTH-1], out[WIDTH-1:1]};
                shift_bit = out[0];
            end
            OP_ROL: begin
                shift_val = {out[WIDTH-2:0], out[WIDTH-1]};
                shift_bit = out[WIDTH-1];
            end
            OP_ROR: begin
                shift_val = {out[0], out[WIDTH-1:1]};
                shift_bit = out[0];
            end
            default: begin
                shift_val = out;
                shift_bit = serial_out;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out        <= '0;
            serial_out <= 1'b0;
            cnt_q      <= '0;
            op_q       <= OP_LOAD;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        cnt_q <= amount;
                        if (op == OP_LOAD) out <= din;
                    end
                end
                SHIFT: begin
                    out        <= shift_val;
                    serial_out <= shift_bit;
                    cnt_q      <= cnt_q - AMT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
